// File: rtl/timebase_pkg.sv
// Shared types and defaults for the timebase controller and its channels.
package timebase_pkg;

    localparam int unsigned TB_CLK_DIV_DEFAULT = 100_000;
    localparam int unsigned TB_PW_DEFAULT      = 16;

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } tb_state_e;

endpackage

// File: rtl/tb_channel.sv
// One post-divider channel: period register, base-tick counter and tick pulse.
module tb_channel
    import timebase_pkg::*;
#(
    parameter int unsigned PW = TB_PW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          adv,
    input  logic          load,
    input  logic [PW-1:0] load_period,
    output logic          tick
);

    logic [PW-1:0] period_q, period_d;
    logic [PW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    // A zero period never advances, so the counter stays at 0 and no tick fires.
    always_comb begin
        period_d = period_q;
        cnt_d    = cnt_q;
        tick_d   = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (adv && (period_q != '0)) begin
            if (cnt_q == period_q - PW'(1)) begin
                tick_d = 1'b1;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + PW'(1);
            end
        end
        if (load) begin
            period_d = load_period;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            period_q <= '0;
            cnt_q    <= '0;
            tick_q   <= 1'b0;
        end else begin
            period_q <= period_d;
            cnt_q    <= cnt_d;
            tick_q   <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/timebase_ctrl.sv
// Shared prescaler plus NCH post-divider channels with boundary-aligned period writes.
// Optional TIMEBASE_FREEZE_EN adds a freeze input that holds all counting.
module timebase_ctrl
    import timebase_pkg::*;
#(
    parameter int unsigned CLK_DIV = TB_CLK_DIV_DEFAULT,
    parameter int unsigned NCH     = 4,
    parameter int unsigned PW      = TB_PW_DEFAULT,
    localparam int unsigned CHW    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
`ifdef TIMEBASE_FREEZE_EN
    input  logic           freeze,
`endif
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [PW-1:0]  cfg_period,
    output logic           base_tick,
    output logic [NCH-1:0] tick,
    output logic           busy
);

    localparam int unsigned PREW = $clog2(CLK_DIV);
    localparam int unsigned LAST = CLK_DIV - 1;

    tb_state_e      state_q, state_d;
    logic [PREW-1:0] pre_q, pre_d, pre_next_c;
    logic           base_tick_q, base_tick_d;
    logic           busy_q, busy_d;
    logic [CHW-1:0] stg_ch_q, stg_ch_d;
    logic [PW-1:0]  stg_period_q, stg_period_d;

    logic           frz_c, accept_c, apply_c, clr_c, adv_c;
    logic [CHW-1:0] apply_ch_c;
    logic [PW-1:0]  apply_period_c;

`ifdef TIMEBASE_FREEZE_EN
    assign frz_c = freeze;
`else
    assign frz_c = 1'b0;
`endif

    assign cfg_ready  = (state_q != ST_PEND);
    assign accept_c   = cfg_valid && cfg_ready;
    assign pre_next_c = (pre_q == PREW'(LAST)) ? '0 : pre_q + PREW'(1);

    // Writes land directly when stopped or stopping; in RUN they are staged and
    // applied on the edge that closes the next base_tick cycle.
    always_comb begin
        state_d        = state_q;
        pre_d          = pre_q;
        stg_ch_d       = stg_ch_q;
        stg_period_d   = stg_period_q;
        apply_c        = 1'b0;
        apply_ch_c     = cfg_ch;
        apply_period_c = cfg_period;
        clr_c          = 1'b0;
        adv_c          = 1'b0;
        unique case (state_q)
            ST_STOP: begin
                pre_d   = '0;
                apply_c = accept_c;
                if (en) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!en) begin
                    state_d = ST_STOP;
                    pre_d   = '0;
                    clr_c   = 1'b1;
                    apply_c = accept_c;
                end else begin
                    if (!frz_c) begin
                        pre_d = pre_next_c;
                        adv_c = (pre_q == PREW'(LAST));
                    end
                    if (accept_c) begin
                        stg_ch_d     = cfg_ch;
                        stg_period_d = cfg_period;
                        state_d      = ST_PEND;
                    end
                end
            end
            ST_PEND: begin
                apply_ch_c     = stg_ch_q;
                apply_period_c = stg_period_q;
                if (!en) begin
                    state_d = ST_STOP;
                    pre_d   = '0;
                    clr_c   = 1'b1;
                    apply_c = 1'b1;
                end else if (!frz_c) begin
                    pre_d = pre_next_c;
                    adv_c = (pre_q == PREW'(LAST));
                    if (base_tick_q) begin
                        apply_c = 1'b1;
                        state_d = ST_RUN;
                    end
                end
            end
            default: state_d = ST_STOP;
        endcase
        base_tick_d = adv_c;
        busy_d      = (state_d == ST_PEND);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_STOP;
            pre_q        <= '0;
            base_tick_q  <= 1'b0;
            busy_q       <= 1'b0;
            stg_ch_q     <= '0;
            stg_period_q <= '0;
        end else begin
            state_q      <= state_d;
            pre_q        <= pre_d;
            base_tick_q  <= base_tick_d;
            busy_q       <= busy_d;
            stg_ch_q     <= stg_ch_d;
            stg_period_q <= stg_period_d;
        end
    end

    assign base_tick = base_tick_q;
    assign busy      = busy_q;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic load_c;
        assign load_c = apply_c && (apply_ch_c == CHW'(i));
        tb_channel #(.PW(PW)) u_ch (
            .clk         (clk),
            .rst         (rst),
            .clr         (clr_c),
            .adv         (adv_c),
            .load        (load_c),
            .load_period (apply_period_c),
            .tick        (tick[i])
        );
    end

endmodule
